test_i7799: RTL and testbench
=============================

TEST_I7799 -- requirements
Module: test_i7799

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 CK  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of CK.
REQ-004 G0  input  1  primary input 0; first positional port.
REQ-005 G1  input  1  primary input 1; second positional port.
REQ-006 G2  input  1  primary input 2; third positional port.
REQ-007 G3  input  1  primary input 3; fourth positional port.
REQ-008 G17  output  1  primary output; last positional port.
REQ-009 Port order SHALL be G0, G1, G2, G3, CK, reset, G17.
REQ-010 A bench driving a 4-bit vector N[0:3] SHALL connect N[0] to G0 and N[3] to G3; N[0] is the leftmost bit of a literal.

Function
REQ-011 State SHALL be exactly three D flip-flops: S5, S6, S7.
REQ-012 Combinational network SHALL be:
- G14 = NOT G0
- G8 = G14 AND S6
- G12 = NOR(G1, S7)
- G13 = NOR(G2, G12)
- G15 = G12 OR G8
- G16 = G3 OR G8
- G9 = NAND(G16, G15)
- G11 = NOR(S5, G9)
- G10 = NOR(G14, G11)
- G17 = NOT G11
REQ-013 Next state on rising CK SHALL be: S5 <= G10, S6 <= G11, S7 <= G13.
REQ-014 G17 SHALL be combinational from inputs and current state (Mealy); changes on G0..G3 propagate without waiting for a clock edge.
REQ-015 Latency: an input change affects state one rising CK edge later.
REQ-016 The design SHALL contain no combinational loops; G11 depends only on S5, S6, S7 and the inputs.
REQ-017 Input changes coincident with the rising CK edge SHALL be sampled with their pre-edge values.
REQ-018 The design SHALL contain no other state, counters, or hidden logic beyond REQ-011..REQ-013.
REQ-019 The design SHALL be synthesizable with one always block for the flip-flops and continuous logic for the gates.

Reset
REQ-020 While reset = 0: S5 = S6 = S7 = 0, and clock edges are ignored.
REQ-021 With state at reset, G17 SHALL equal NOT(G3 AND NOT G1).
REQ-022 Reset assertion mid-operation SHALL clear state at once, and G17 SHALL re-evaluate combinationally.
REQ-023 Deassertion SHALL take effect at the next rising CK edge; no synchronizer is inside the block.

Verification
REQ-024 Reset, G0..G3 = 0000 -> G17 = 1; with G0..G3 = 0001 -> G17 = 0 immediately.
REQ-025 After reset, G0..G3 = 0001, one rising CK -> S6 = 1, S5 = S7 = 0; then G0..G3 = 0000 -> G17 = 0.
REQ-026 After reset, G0..G3 = 1000, one rising CK -> S5 = 1, S6 = S7 = 0; then G0..G3 = 0001 -> G17 = 1.
REQ-027 After reset, G0..G3 = 0100, one rising CK -> S7 = 1, S5 = S6 = 0; then G0..G3 = 0001 -> G17 = 1.
REQ-028 Run the REQ-025 sequence, then pull reset low between edges with G0..G3 = 0000 -> state = 000 and G17 = 1 with no CK edge.
REQ-029 Exhaustive check: all 16 input values x all 8 states -> G17 and next state match REQ-012/REQ-013.

Source files
------------

// File: rtl/test_i7799_if.sv
// Bundle of the four primary inputs and the single primary output of test_i7799.
// The core keeps its fixed positional port list, so the bench wires these members to it.
interface test_i7799_if;
  logic G0;
  logic G1;
  logic G2;
  logic G3;
  logic G17;

  modport master (output G0, output G1, output G2, output G3, input G17);
  modport slave (input G0, input G1, input G2, input G3, output G17);
endinterface

// File: rtl/test_i7799.sv
// Three-flop gate-level sequential cell: S5/S6/S7 state with a Mealy output G17.
// The gate network is kept in its original form so each net can be traced by name.
module test_i7799 (
  input  logic G0,
  input  logic G1,
  input  logic G2,
  input  logic G3,
  input  logic CK,
  input  logic reset,
  output logic G17
);

  logic s5, s6, s7;
  logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

  // G11 only sees S5..S7 and the inputs, so the network has no loop.
  assign g14 = ~G0;
  assign g8  = g14 & s6;
  assign g12 = ~(G1 | s7);
  assign g13 = ~(G2 | g12);
  assign g15 = g12 | g8;
  assign g16 = G3 | g8;
  assign g9  = ~(g16 & g15);
  assign g11 = ~(s5 | g9);
  assign g10 = ~(g14 | g11);
  assign G17 = ~g11;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      s5 <= 1'b0;
      s6 <= 1'b0;
      s7 <= 1'b0;
    end else begin
      s5 <= g10;
      s6 <= g11;
      s7 <= g13;
    end
  end

endmodule

// File: tb/tb_test_i7799.sv
// Directed table plus steered exhaustive sweep for test_i7799.
// Vectors are written N[0:3] with N[0] (leftmost) driving G0.
module tb_test_i7799;

  logic CK;
  logic reset;
  int checkCount;
  int passCount;

  test_i7799_if bus ();

  test_i7799 dut (
    .G0    (bus.G0),
    .G1    (bus.G1),
    .G2    (bus.G2),
    .G3    (bus.G3),
    .CK    (CK),
    .reset (reset),
    .G17   (bus.G17)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic [0:3] inA;
    logic       g17A;
    logic [2:0] stateA;
    logic [0:3] inB;
    logic       g17B;
  } vec_t;

  vec_t vecs[6];

  // Behavioural reference: returns {G17, S5', S6', S7'}.
  function automatic logic [3:0] model(input logic [2:0] st, input logic [0:3] n);
    logic a0, a1, a2, a3, q5, q6, q7, mid, nor12, out11;
    a0 = n[0]; a1 = n[1]; a2 = n[2]; a3 = n[3];
    q5 = st[2]; q6 = st[1]; q7 = st[0];
    mid   = !a0 && q6;
    nor12 = !(a1 || q7);
    out11 = !q5 && (a3 || mid) && (nor12 || mid);
    return {!out11, a0 && !out11, out11, !a2 && !nor12};
  endfunction

  task automatic applyStimulus(input logic [0:3] n);
    bus.G0 = n[0];
    bus.G1 = n[1];
    bus.G2 = n[2];
    bus.G3 = n[3];
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  function automatic logic [2:0] dutState();
    return {dut.s5, dut.s6, dut.s7};
  endfunction

  // Pulses reset low between edges, leaving it released before the next rising CK.
  task automatic pulseReset();
    @(negedge CK);
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic stepClock();
    @(posedge CK);
    #1;
  endtask

  task automatic findPath(input logic [2:0] target, output bit found, output int len,
                          output logic [0:3] a, output logic [0:3] b);
    logic [0:3] x, y;
    found = 0; len = 0; a = '0; b = '0;
    for (int i = 0; i < 16 && !found; i++) begin
      x = 4'(i);
      if (model(3'b000, x)[2:0] == target) begin
        found = 1; len = 1; a = x;
      end
    end
    for (int i = 0; i < 16 && !found; i++) begin
      x = 4'(i);
      for (int j = 0; j < 16 && !found; j++) begin
        y = 4'(j);
        if (model(model(3'b000, x)[2:0], y)[2:0] == target) begin
          found = 1; len = 2; a = x; b = y;
        end
      end
    end
  endtask

  initial begin
    bit found;
    int len;
    logic [0:3] pa, pb, n;
    logic [3:0] exp;

    checkCount = 0;
    passCount  = 0;
    reset = 1'b0;
    applyStimulus(4'b0000);

    vecs[0] = '{inA: 4'b0001, g17A: 1'b0, stateA: 3'b010, inB: 4'b0000, g17B: 1'b0};
    vecs[1] = '{inA: 4'b1000, g17A: 1'b1, stateA: 3'b100, inB: 4'b0001, g17B: 1'b1};
    vecs[2] = '{inA: 4'b0100, g17A: 1'b1, stateA: 3'b001, inB: 4'b0001, g17B: 1'b1};
    vecs[3] = '{inA: 4'b0000, g17A: 1'b1, stateA: 3'b000, inB: 4'b0001, g17B: 1'b0};
    vecs[4] = '{inA: 4'b1101, g17A: 1'b1, stateA: 3'b101, inB: 4'b0000, g17B: 1'b1};
    vecs[5] = '{inA: 4'b0011, g17A: 1'b0, stateA: 3'b010, inB: 4'b1111, g17B: 1'b1};

    #2;
    checkOutput("reset_state", {1'b0, dutState()}, 4'b0000);
    checkOutput("reset_g17_0000", {3'b000, bus.G17}, 4'b0001);
    applyStimulus(4'b0001);
    #1;
    checkOutput("reset_g17_0001", {3'b000, bus.G17}, 4'b0000);

    // Clock edges must be ignored while reset is held low.
    stepClock();
    checkOutput("held_reset_state", {1'b0, dutState()}, 4'b0000);
    @(negedge CK);
    reset = 1'b1;

    for (int v = 0; v < 6; v++) begin
      pulseReset();
      applyStimulus(vecs[v].inA);
      #1;
      checkOutput($sformatf("vec%0d_g17A", v), {3'b000, bus.G17}, {3'b000, vecs[v].g17A});
      stepClock();
      checkOutput($sformatf("vec%0d_state", v), {1'b0, dutState()}, {1'b0, vecs[v].stateA});
      @(negedge CK);
      applyStimulus(vecs[v].inB);
      #1;
      checkOutput($sformatf("vec%0d_g17B", v), {3'b000, bus.G17}, {3'b000, vecs[v].g17B});
    end

    // Mid-cycle reset clears state and G17 follows without a clock edge.
    pulseReset();
    applyStimulus(4'b0001);
    stepClock();
    checkOutput("midrst_pre_state", {1'b0, dutState()}, 4'b0010);
    @(negedge CK);
    applyStimulus(4'b0000);
    #1;
    checkOutput("midrst_pre_g17", {3'b000, bus.G17}, 4'b0000);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_state", {1'b0, dutState()}, 4'b0000);
    checkOutput("midrst_g17", {3'b000, bus.G17}, 4'b0001);
    applyStimulus(4'b0001);
    #1;
    reset = 1'b1;
    stepClock();
    checkOutput("release_first_edge", {1'b0, dutState()}, 4'b0010);

    // Every reachable state is steered to afresh for each of the 16 inputs.
    for (int t = 0; t < 8; t++) begin
      findPath(3'(t), found, len, pa, pb);
      if (!found) begin
        $display("[TB] state %b not reachable from reset, skipped", 3'(t));
        continue;
      end
      for (int i = 0; i < 16; i++) begin
        n = 4'(i);
        pulseReset();
        applyStimulus(pa);
        stepClock();
        if (len == 2) begin
          @(negedge CK);
          applyStimulus(pb);
          stepClock();
        end
        @(negedge CK);
        applyStimulus(n);
        #1;
        exp = model(3'(t), n);
        checkOutput($sformatf("sweep_s%b_n%b_g17", 3'(t), n), {3'b000, bus.G17}, {3'b000, exp[3]});
        stepClock();
        checkOutput($sformatf("sweep_s%b_n%b_next", 3'(t), n), {1'b0, dutState()}, {1'b0, exp[2:0]});
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
